// File: rtl/mult_accumulate.sv
// Sequential shift-and-add unsigned multiplier: product = multiplicand * multiplier + addend.
// One multiplier bit is consumed per cycle; the handshake is a valid-in pulse, busy, and a valid-out pulse.
module mult_accumulate #(
   parameter int WIDTH = 32
) (
   input  logic             clk_in,
   input  logic             rst_in,
   input  logic [WIDTH-1:0] multiplicand_in,
   input  logic [WIDTH-1:0] multiplier_in,
   input  logic [WIDTH-1:0] addend_in,
   input  logic             data_valid_in,
   output logic [WIDTH-1:0] product_out,
   output logic             overflow_out,
   output logic             data_valid_out,
   output logic             busy_out
);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      MULT = 1'b1
   } state_t;

   state_t               state;
   state_t               state_nx;
   logic [2*WIDTH-1:0]   acc;
   logic [2*WIDTH-1:0]   acc_nx;
   logic [2*WIDTH-1:0]   mcand;
   logic [2*WIDTH-1:0]   mcand_nx;
   logic [WIDTH-1:0]     mplier;
   logic [WIDTH-1:0]     mplier_nx;
   logic [WIDTH-1:0]     product_nx;
   logic                 overflow_nx;
   logic                 valid_nx;
   logic                 busy_nx;

   // Next-state and datapath: acc cannot wrap because A*B+C < 2**(2*WIDTH).
   always_comb begin
      state_nx    = state;
      acc_nx      = acc;
      mcand_nx    = mcand;
      mplier_nx   = mplier;
      product_nx  = product_out;
      overflow_nx = overflow_out;
      valid_nx    = 1'b0;
      busy_nx     = busy_out;
      case (state)
         IDLE: begin
            if (data_valid_in) begin
               acc_nx    = {{WIDTH{1'b0}}, addend_in};
               mcand_nx  = {{WIDTH{1'b0}}, multiplicand_in};
               mplier_nx = multiplier_in;
               busy_nx   = 1'b1;
               state_nx  = MULT;
            end else begin
               state_nx  = IDLE;
            end
         end
         MULT: begin
            if (mplier == {WIDTH{1'b0}}) begin
               product_nx  = acc[WIDTH-1:0];
               overflow_nx = |acc[2*WIDTH-1:WIDTH];
               valid_nx    = 1'b1;
               busy_nx     = 1'b0;
               state_nx    = IDLE;
            end else begin
               if (mplier[0]) begin
                  acc_nx = acc + mcand;
               end else begin
                  acc_nx = acc;
               end
               mcand_nx  = {mcand[2*WIDTH-2:0], 1'b0};
               mplier_nx = {1'b0, mplier[WIDTH-1:1]};
               state_nx  = MULT;
            end
         end
         default: begin
            state_nx = IDLE;
            busy_nx  = 1'b0;
         end
      endcase
   end

   // State, datapath and output registers; reset aborts any operation in flight.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state          <= IDLE;
         acc            <= {(2*WIDTH){1'b0}};
         mcand          <= {(2*WIDTH){1'b0}};
         mplier         <= {WIDTH{1'b0}};
         product_out    <= {WIDTH{1'b0}};
         overflow_out   <= 1'b0;
         data_valid_out <= 1'b0;
         busy_out       <= 1'b0;
      end else begin
         state          <= state_nx;
         acc            <= acc_nx;
         mcand          <= mcand_nx;
         mplier         <= mplier_nx;
         product_out    <= product_nx;
         overflow_out   <= overflow_nx;
         data_valid_out <= valid_nx;
         busy_out       <= busy_nx;
      end
   end

endmodule

// File: tb/tb_mult_accumulate.sv
// Scoreboard bench for mult_accumulate at WIDTH 8, 16 and 32: expectations are queued at issue
// and popped on each valid pulse, checking product, overflow and exact completion cycle.
module tb_mult_accumulate;

   typedef struct {
      logic [31:0] p;
      logic        ov;
      int          done;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] a = 32'd0;
   logic [31:0] b = 32'd0;
   logic [31:0] c = 32'd0;
   logic        dv8 = 1'b0, dv16 = 1'b0, dv32 = 1'b0;
   logic [7:0]  p8;
   logic [15:0] p16;
   logic [31:0] p32;
   logic        ov8, ov16, ov32, v8, v16, v32, bz8, bz16, bz32;

   int   cyc = 0;
   int   total = 0;
   int   bad = 0;
   exp_t q8[$];
   exp_t q16[$];
   exp_t q32[$];

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   mult_accumulate #(.WIDTH(8)) u8 (
      .clk_in(clk), .rst_in(rst), .multiplicand_in(a[7:0]), .multiplier_in(b[7:0]),
      .addend_in(c[7:0]), .data_valid_in(dv8), .product_out(p8), .overflow_out(ov8),
      .data_valid_out(v8), .busy_out(bz8));

   mult_accumulate #(.WIDTH(16)) u16 (
      .clk_in(clk), .rst_in(rst), .multiplicand_in(a[15:0]), .multiplier_in(b[15:0]),
      .addend_in(c[15:0]), .data_valid_in(dv16), .product_out(p16), .overflow_out(ov16),
      .data_valid_out(v16), .busy_out(bz16));

   mult_accumulate #(.WIDTH(32)) u32 (
      .clk_in(clk), .rst_in(rst), .multiplicand_in(a), .multiplier_in(b),
      .addend_in(c), .data_valid_in(dv32), .product_out(p32), .overflow_out(ov32),
      .data_valid_out(v32), .busy_out(bz32));

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic int bitlen(input logic [31:0] v);
      int n = 0;
      for (int i = 0; i < 32; i++) if (v[i]) n = i + 1;
      return n;
   endfunction

   function automatic logic get_valid(input int w);
      case (w)
         8:       return v8;
         16:      return v16;
         default: return v32;
      endcase
   endfunction

   function automatic logic get_busy(input int w);
      case (w)
         8:       return bz8;
         16:      return bz16;
         default: return bz32;
      endcase
   endfunction

   function automatic int qsize(input int w);
      case (w)
         8:       return q8.size();
         16:      return q16.size();
         default: return q32.size();
      endcase
   endfunction

   // Called at a negedge: drives one capture pulse, optionally queues the expected result.
   task automatic issue(input int w, input logic [31:0] av, input logic [31:0] bv,
                        input logic [31:0] cv, input bit push);
      logic [63:0] mask, full;
      exp_t        e;
      mask   = (64'd1 << w) - 64'd1;
      full   = ({32'd0, av} & mask) * ({32'd0, bv} & mask) + ({32'd0, cv} & mask);
      e.p    = full[31:0] & mask[31:0];
      e.ov   = ((full >> w) != 64'd0);
      e.done = cyc + bitlen(bv & mask[31:0]) + 2;
      a = av; b = bv; c = cv;
      case (w)
         8:       dv8 = 1'b1;
         16:      dv16 = 1'b1;
         default: dv32 = 1'b1;
      endcase
      if (push) begin
         case (w)
            8:       q8.push_back(e);
            16:      q16.push_back(e);
            default: q32.push_back(e);
         endcase
      end
      @(negedge clk);
      dv8 = 1'b0; dv16 = 1'b0; dv32 = 1'b0;
      a = $urandom; b = $urandom; c = $urandom;
   endtask

   task automatic wait_valid(input int w);
      int n = 0;
      while (!get_valid(w) && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!get_valid(w)) check($sformatf("w%0d_wait_valid_timeout", w), 64'd0, 64'd1);
   endtask

   task automatic wait_done(input int w);
      int n = 0;
      while ((get_busy(w) || qsize(w) != 0) && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (get_busy(w) || qsize(w) != 0) check($sformatf("w%0d_done_timeout", w), 64'd0, 64'd1);
      @(negedge clk);
   endtask

   task automatic mon(input int w, input logic [31:0] p, input logic ov);
      exp_t e;
      bit   have = 1'b0;
      case (w)
         8:       if (q8.size() > 0) begin e = q8.pop_front(); have = 1'b1; end
         16:      if (q16.size() > 0) begin e = q16.pop_front(); have = 1'b1; end
         default: if (q32.size() > 0) begin e = q32.pop_front(); have = 1'b1; end
      endcase
      if (!have) begin
         check($sformatf("w%0d_unexpected_valid", w), 64'd1, 64'd0);
      end else begin
         check($sformatf("w%0d_product", w), {32'd0, p}, {32'd0, e.p});
         check($sformatf("w%0d_overflow", w), {63'd0, ov}, {63'd0, e.ov});
         check($sformatf("w%0d_latency", w), 64'(cyc), 64'(e.done));
      end
   endtask

   always @(negedge clk) if (!rst && v8)  mon(8,  {24'd0, p8},  ov8);
   always @(negedge clk) if (!rst && v16) mon(16, {16'd0, p16}, ov16);
   always @(negedge clk) if (!rst && v32) mon(32, p32, ov32);

   initial begin
      repeat (2) @(negedge clk);
      check("rst_product8", {56'd0, p8}, 64'd0);
      check("rst_busy8", {63'd0, bz8}, 64'd0);
      check("rst_valid8", {63'd0, v8}, 64'd0);
      check("rst_overflow32", {63'd0, ov32}, 64'd0);
      rst = 1'b0;
      @(negedge clk);

      // Directed W=8 vectors.
      issue(8, 32'd7, 32'd6, 32'd3, 1'b1);     wait_done(8);
      issue(8, 32'd200, 32'd0, 32'd17, 1'b1);  wait_done(8);
      issue(8, 32'd255, 32'd255, 32'd255, 1'b1); wait_done(8);
      issue(8, 32'd0, 32'd128, 32'd9, 1'b1);   wait_done(8);

      // Round trip with the divider: 100 / 7 = 14 r 2.
      issue(32, 32'd14, 32'd7, 32'd2, 1'b1);   wait_done(32);
      issue(32, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1); wait_done(32);

      // Operand pulse while busy is dropped; next op issued in the IDLE cycle after the pulse.
      issue(8, 32'd3, 32'd5, 32'd0, 1'b1);
      issue(8, 32'd9, 32'd9, 32'd9, 1'b0);
      check("busy_during_op", {63'd0, bz8}, 64'd1);
      wait_valid(8);
      issue(8, 32'd2, 32'd2, 32'd1, 1'b1);
      wait_done(8);

      // Reset mid-operation aborts without a valid pulse.
      issue(8, 32'd255, 32'd255, 32'd255, 1'b0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("abort_busy", {63'd0, bz8}, 64'd0);
      check("abort_product", {56'd0, p8}, 64'd0);
      check("abort_overflow", {63'd0, ov8}, 64'd0);
      check("abort_valid", {63'd0, v8}, 64'd0);
      rst = 1'b0;
      repeat (12) @(negedge clk);
      issue(8, 32'd7, 32'd6, 32'd3, 1'b1);     wait_done(8);

      // Random W=16 sweep, including the widest multiplier.
      issue(16, 32'hFFFF, 32'hFFFF, 32'hFFFF, 1'b1); wait_done(16);
      for (int i = 0; i < 30; i++) begin
         issue(16, $urandom_range(0, 65535), $urandom_range(0, 65535),
               $urandom_range(0, 65535), 1'b1);
         wait_done(16);
      end

      check("pending8", 64'(q8.size()), 64'd0);
      check("pending16", 64'(q16.size()), 64'd0);
      check("pending32", 64'(q32.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
